memory_arbiter: RTL and testbench

MEMORY_ARBITER -- requirements
Module: MEMORY_ARBITER

---
 rtl/memory_arbiter.sv | 155 +++++++++++++++
 tb/tb_memory_arbiter.sv | 166 ++++++++++++++++
 2 files changed

// File: rtl/memory_arbiter.sv
// Two-port (fetch / data) round-robin arbiter onto a single main-memory port; every output is registered.
// Request in IDLE cycle N -> memory strobes from N+1 -> DONE between N+2 (ACK) and N+1+TIMEOUT_CYCLES (timeout).
module memory_arbiter #(
   parameter int DATAWIDTH_BUS  = 32,
   parameter int TIMEOUT_CYCLES = 4
) (
   input  logic                     MEMORY_ARBITER_CLOCK_50,
   input  logic                     MEMORY_ARBITER_RESET_InHigh,
   input  logic                     MEMORY_ARBITER_IF_REQ_In,
   input  logic [DATAWIDTH_BUS-1:0] MEMORY_ARBITER_IF_ADDRESS_InBUS,
   output logic [DATAWIDTH_BUS-1:0] MEMORY_ARBITER_IF_data_OutBUS,
   output logic                     MEMORY_ARBITER_IF_DONE_Out,
   input  logic                     MEMORY_ARBITER_DM_REQ_In,
   input  logic                     MEMORY_ARBITER_DM_WR_In,
   input  logic [DATAWIDTH_BUS-1:0] MEMORY_ARBITER_DM_ADDRESS_InBUS,
   input  logic [DATAWIDTH_BUS-1:0] MEMORY_ARBITER_DM_data_InBUS,
   output logic [DATAWIDTH_BUS-1:0] MEMORY_ARBITER_DM_data_OutBUS,
   output logic                     MEMORY_ARBITER_DM_DONE_Out,
   output logic [DATAWIDTH_BUS-1:0] MEMORY_ARBITER_MEM_ADDRESS_OutBUS,
   output logic [DATAWIDTH_BUS-1:0] MEMORY_ARBITER_MEM_data_OutBUS,
   output logic                     MEMORY_ARBITER_MEM_RD_Out,
   output logic                     MEMORY_ARBITER_MEM_WR_Out,
   input  logic [DATAWIDTH_BUS-1:0] MEMORY_ARBITER_MEM_data_InBUS,
   input  logic                     MEMORY_ARBITER_MEM_ACK_In,
   output logic                     MEMORY_ARBITER_BUSY_Out,
   output logic                     MEMORY_ARBITER_TIMEOUT_Out
);

   localparam int CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

   typedef enum logic [1:0] {ST_IDLE, ST_ACCESS, ST_DONE} state_t;

   state_t                   r_state, w_state_next;
   logic [CW-1:0]            r_cnt, w_cnt_n;
   logic                     r_gnt_dm, w_gnt_dm_n;
   logic                     r_last_dm, w_last_dm_n;
   logic                     r_wr, w_wr_n;
   logic [DATAWIDTH_BUS-1:0] r_addr, w_addr_n;
   logic [DATAWIDTH_BUS-1:0] r_wdata, w_wdata_n;

   logic                     r_mem_rd, w_mem_rd_n;
   logic                     r_mem_wr, w_mem_wr_n;
   logic [DATAWIDTH_BUS-1:0] r_mem_addr, w_mem_addr_n;
   logic [DATAWIDTH_BUS-1:0] r_mem_wdata, w_mem_wdata_n;
   logic [DATAWIDTH_BUS-1:0] r_if_data, w_if_data_n;
   logic [DATAWIDTH_BUS-1:0] r_dm_data, w_dm_data_n;
   logic                     r_if_done, w_if_done_n;
   logic                     r_dm_done, w_dm_done_n;
   logic                     r_timeout, w_timeout_n;
   logic                     r_busy, w_busy_n;

   logic                     w_any_req;
   logic                     w_sel_dm;
   logic                     w_complete;
   logic                     w_access_n;

   // On a tie the port that did not win last time gets the bus.
   assign w_any_req  = MEMORY_ARBITER_IF_REQ_In | MEMORY_ARBITER_DM_REQ_In;
   assign w_sel_dm   = MEMORY_ARBITER_DM_REQ_In & (~MEMORY_ARBITER_IF_REQ_In | ~r_last_dm);
   assign w_complete = (r_state == ST_ACCESS) &&
                       (MEMORY_ARBITER_MEM_ACK_In || (r_cnt == CW'(TIMEOUT_CYCLES - 1)));

   always_ff @(posedge MEMORY_ARBITER_CLOCK_50) begin
      if (MEMORY_ARBITER_RESET_InHigh) r_state <= ST_IDLE;
      else                             r_state <= w_state_next;
   end

   always_comb begin
      w_state_next = r_state;
      case (r_state)
         ST_IDLE:   if (w_any_req)  w_state_next = ST_ACCESS;
         ST_ACCESS: if (w_complete) w_state_next = ST_DONE;
         ST_DONE:                   w_state_next = ST_IDLE;
         default:                   w_state_next = ST_IDLE;
      endcase
   end

   // Output values are computed for the next state so that every port comes straight off a flop.
   always_comb begin
      w_gnt_dm_n  = r_gnt_dm;
      w_last_dm_n = r_last_dm;
      w_wr_n      = r_wr;
      w_addr_n    = r_addr;
      w_wdata_n   = r_wdata;
      if (r_state == ST_IDLE && w_any_req) begin
         w_gnt_dm_n  = w_sel_dm;
         w_last_dm_n = w_sel_dm;
         w_wr_n      = w_sel_dm & MEMORY_ARBITER_DM_WR_In;
         w_addr_n    = w_sel_dm ? MEMORY_ARBITER_DM_ADDRESS_InBUS : MEMORY_ARBITER_IF_ADDRESS_InBUS;
         w_wdata_n   = w_sel_dm ? MEMORY_ARBITER_DM_data_InBUS : '0;
      end
      w_access_n    = (w_state_next == ST_ACCESS);
      w_mem_rd_n    = w_access_n & ~w_wr_n;
      w_mem_wr_n    = w_access_n & w_wr_n;
      w_mem_addr_n  = w_access_n ? w_addr_n : '0;
      w_mem_wdata_n = (w_access_n && w_wr_n) ? w_wdata_n : '0;
      w_cnt_n       = (r_state == ST_ACCESS && w_access_n) ? r_cnt + 1'b1 : '0;
      w_if_done_n   = w_complete & ~r_gnt_dm;
      w_dm_done_n   = w_complete & r_gnt_dm;
      w_timeout_n   = w_complete & ~MEMORY_ARBITER_MEM_ACK_In;
      w_if_data_n   = (w_complete && !r_gnt_dm) ? MEMORY_ARBITER_MEM_data_InBUS : r_if_data;
      w_dm_data_n   = (w_complete && r_gnt_dm && !r_wr) ? MEMORY_ARBITER_MEM_data_InBUS : r_dm_data;
      w_busy_n      = (w_state_next != ST_IDLE);
   end

   always_ff @(posedge MEMORY_ARBITER_CLOCK_50) begin
      if (MEMORY_ARBITER_RESET_InHigh) begin
         r_cnt       <= '0;
         r_gnt_dm    <= 1'b0;
         r_last_dm   <= 1'b1;
         r_wr        <= 1'b0;
         r_addr      <= '0;
         r_wdata     <= '0;
         r_mem_rd    <= 1'b0;
         r_mem_wr    <= 1'b0;
         r_mem_addr  <= '0;
         r_mem_wdata <= '0;
         r_if_data   <= '0;
         r_dm_data   <= '0;
         r_if_done   <= 1'b0;
         r_dm_done   <= 1'b0;
         r_timeout   <= 1'b0;
         r_busy      <= 1'b0;
      end else begin
         r_cnt       <= w_cnt_n;
         r_gnt_dm    <= w_gnt_dm_n;
         r_last_dm   <= w_last_dm_n;
         r_wr        <= w_wr_n;
         r_addr      <= w_addr_n;
         r_wdata     <= w_wdata_n;
         r_mem_rd    <= w_mem_rd_n;
         r_mem_wr    <= w_mem_wr_n;
         r_mem_addr  <= w_mem_addr_n;
         r_mem_wdata <= w_mem_wdata_n;
         r_if_data   <= w_if_data_n;
         r_dm_data   <= w_dm_data_n;
         r_if_done   <= w_if_done_n;
         r_dm_done   <= w_dm_done_n;
         r_timeout   <= w_timeout_n;
         r_busy      <= w_busy_n;
      end
   end

   assign MEMORY_ARBITER_IF_data_OutBUS     = r_if_data;
   assign MEMORY_ARBITER_IF_DONE_Out        = r_if_done;
   assign MEMORY_ARBITER_DM_data_OutBUS     = r_dm_data;
   assign MEMORY_ARBITER_DM_DONE_Out        = r_dm_done;
   assign MEMORY_ARBITER_MEM_ADDRESS_OutBUS = r_mem_addr;
   assign MEMORY_ARBITER_MEM_data_OutBUS    = r_mem_wdata;
   assign MEMORY_ARBITER_MEM_RD_Out         = r_mem_rd;
   assign MEMORY_ARBITER_MEM_WR_Out         = r_mem_wr;
   assign MEMORY_ARBITER_BUSY_Out           = r_busy;
   assign MEMORY_ARBITER_TIMEOUT_Out        = r_timeout;

endmodule

// File: tb/tb_memory_arbiter.sv
// Directed bench for memory_arbiter (DATAWIDTH_BUS=32, TIMEOUT_CYCLES=4); outputs sampled 1ns after each rising edge.
module tb_memory_arbiter;

   logic        clk = 1'b0;
   logic        rst;
   logic        if_req, dm_req, dm_wr, mem_ack;
   logic [31:0] if_addr, dm_addr, dm_wdata, mem_rdata;
   logic [31:0] if_data, dm_data, mem_addr, mem_wdata;
   logic        if_done, dm_done, mem_rd, mem_wr, busy, tmo;

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   memory_arbiter #(.DATAWIDTH_BUS(32), .TIMEOUT_CYCLES(4)) dut (
      .MEMORY_ARBITER_CLOCK_50          (clk),
      .MEMORY_ARBITER_RESET_InHigh      (rst),
      .MEMORY_ARBITER_IF_REQ_In         (if_req),
      .MEMORY_ARBITER_IF_ADDRESS_InBUS  (if_addr),
      .MEMORY_ARBITER_IF_data_OutBUS    (if_data),
      .MEMORY_ARBITER_IF_DONE_Out       (if_done),
      .MEMORY_ARBITER_DM_REQ_In         (dm_req),
      .MEMORY_ARBITER_DM_WR_In          (dm_wr),
      .MEMORY_ARBITER_DM_ADDRESS_InBUS  (dm_addr),
      .MEMORY_ARBITER_DM_data_InBUS     (dm_wdata),
      .MEMORY_ARBITER_DM_data_OutBUS    (dm_data),
      .MEMORY_ARBITER_DM_DONE_Out       (dm_done),
      .MEMORY_ARBITER_MEM_ADDRESS_OutBUS(mem_addr),
      .MEMORY_ARBITER_MEM_data_OutBUS   (mem_wdata),
      .MEMORY_ARBITER_MEM_RD_Out        (mem_rd),
      .MEMORY_ARBITER_MEM_WR_Out        (mem_wr),
      .MEMORY_ARBITER_MEM_data_InBUS    (mem_rdata),
      .MEMORY_ARBITER_MEM_ACK_In        (mem_ack),
      .MEMORY_ARBITER_BUSY_Out          (busy),
      .MEMORY_ARBITER_TIMEOUT_Out       (tmo)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   initial begin
      rst = 1'b1; if_req = 1'b0; dm_req = 1'b0; dm_wr = 1'b0; mem_ack = 1'b0;
      if_addr = '0; dm_addr = '0; dm_wdata = '0; mem_rdata = '0;
      tick(); tick();

      // Reset state
      chk("rst_busy", busy, 0);       chk("rst_rd", mem_rd, 0);
      chk("rst_wr", mem_wr, 0);       chk("rst_addr", mem_addr, 0);
      chk("rst_wdata", mem_wdata, 0); chk("rst_if_done", if_done, 0);
      chk("rst_dm_done", dm_done, 0); chk("rst_tmo", tmo, 0);
      chk("rst_if_data", if_data, 0); chk("rst_dm_data", dm_data, 0);

      // Fetch read with no ACK: four ACCESS cycles then timeout completion
      rst = 1'b0; if_req = 1'b1; if_addr = 32'h000; mem_rdata = 32'h10800800;
      tick();
      if_req = 1'b0;
      chk("to_rd_c2", mem_rd, 1); chk("to_wr_c2", mem_wr, 0);
      chk("to_busy_c2", busy, 1); chk("to_addr_c2", mem_addr, 32'h000);
      chk("to_wdata_c2", mem_wdata, 0);
      for (int i = 3; i <= 5; i++) begin
         tick();
         chk($sformatf("to_rd_c%0d", i), mem_rd, 1);
         chk($sformatf("to_done_c%0d", i), if_done, 0);
      end
      tick();
      chk("to_rd_c6", mem_rd, 0);      chk("to_if_done_c6", if_done, 1);
      chk("to_tmo_c6", tmo, 1);        chk("to_dm_done_c6", dm_done, 0);
      chk("to_if_data_c6", if_data, 32'h10800800);
      chk("to_busy_c6", busy, 1);
      tick();
      chk("to_if_done_c7", if_done, 0); chk("to_tmo_c7", tmo, 0);
      chk("to_busy_c7", busy, 0);

      // Data-port write acknowledged in its first ACCESS cycle
      dm_req = 1'b1; dm_wr = 1'b1; dm_addr = 32'h840; dm_wdata = 32'hDEADBEEF;
      mem_rdata = 32'h12345678;
      tick();
      dm_req = 1'b0; mem_ack = 1'b1;
      chk("wr_wr", mem_wr, 1);  chk("wr_rd", mem_rd, 0);
      chk("wr_addr", mem_addr, 32'h840); chk("wr_wdata", mem_wdata, 32'hDEADBEEF);
      tick();
      mem_ack = 1'b0;
      chk("wr_dm_done", dm_done, 1); chk("wr_tmo", tmo, 0);
      chk("wr_wr_off", mem_wr, 0);   chk("wr_addr_off", mem_addr, 0);
      chk("wr_dm_data", dm_data, 0); chk("wr_if_data", if_data, 32'h10800800);
      tick();
      chk("wr_dm_done_end", dm_done, 0);

      // Both ports held high with immediate ACK: grants alternate IF, DM, IF, DM
      if_req = 1'b1; dm_req = 1'b1; dm_wr = 1'b0; mem_ack = 1'b1;
      if_addr = 32'h100; dm_addr = 32'h200;
      for (int i = 0; i < 4; i++) begin
         mem_rdata = 32'hA5A50000 + i;
         tick();
         chk($sformatf("rr%0d_addr", i), mem_addr, (i % 2 == 1) ? 32'h200 : 32'h100);
         chk($sformatf("rr%0d_rd", i), mem_rd, 1);
         chk($sformatf("rr%0d_wr", i), mem_wr, 0);
         tick();
         chk($sformatf("rr%0d_if_done", i), if_done, (i % 2 == 1) ? 0 : 1);
         chk($sformatf("rr%0d_dm_done", i), dm_done, (i % 2 == 1) ? 1 : 0);
         chk($sformatf("rr%0d_data", i), (i % 2 == 1) ? dm_data : if_data, 32'hA5A50000 + i);
         chk($sformatf("rr%0d_rd_off", i), mem_rd, 0);
         tick();
         chk($sformatf("rr%0d_idle", i), busy, 0);
      end
      if_req = 1'b0; dm_req = 1'b0; mem_ack = 1'b0;

      // ACK arrives exactly on the last ACCESS cycle; address changes mid-access are ignored
      if_req = 1'b1; if_addr = 32'h44; mem_rdata = 32'h0BADF00D;
      tick();
      if_req = 1'b0; if_addr = 32'h99;
      tick(); tick();
      chk("late_addr_hold", mem_addr, 32'h44);
      tick();
      mem_ack = 1'b1;
      chk("late_rd_c4", mem_rd, 1);
      tick();
      mem_ack = 1'b0;
      chk("late_if_done", if_done, 1); chk("late_tmo", tmo, 0);
      chk("late_if_data", if_data, 32'h0BADF00D);
      tick();
      chk("late_single_pulse", if_done, 0); chk("late_busy", busy, 0);

      // Reset in the second ACCESS cycle aborts the access
      dm_req = 1'b1; dm_wr = 1'b0; dm_addr = 32'h300;
      tick();
      dm_req = 1'b0;
      tick();
      chk("ab_rd_c2", mem_rd, 1);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      chk("ab_rd", mem_rd, 0);       chk("ab_wr", mem_wr, 0);
      chk("ab_busy", busy, 0);       chk("ab_dm_done", dm_done, 0);
      chk("ab_tmo", tmo, 0);         chk("ab_addr", mem_addr, 0);
      chk("ab_if_data", if_data, 0); chk("ab_dm_data", dm_data, 0);
      tick();
      chk("ab_dm_done_after", dm_done, 0); chk("ab_busy_after", busy, 0);

      // Lone data request after reset is granted despite history favouring IF
      dm_req = 1'b1; dm_addr = 32'h500; mem_ack = 1'b1; mem_rdata = 32'hCAFE0005;
      tick();
      dm_req = 1'b0;
      chk("solo_addr", mem_addr, 32'h500); chk("solo_rd", mem_rd, 1);
      tick();
      mem_ack = 1'b0;
      chk("solo_dm_done", dm_done, 1); chk("solo_if_done", if_done, 0);
      chk("solo_dm_data", dm_data, 32'hCAFE0005);
      tick();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
